// File: rtl/pipeline_stall_ctrl.sv
// Hazard/stall sequencer for the 5-stage pipeline: per-stage write/flush
// controls, mul/div occupancy counter, memory-wait timeout and stall counter.
module pipeline_stall_ctrl #(
  parameter int MD_LAT      = 8,
  parameter int MEM_TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  IF_ID_RegisterRs,
  input  logic [4:0]  IF_ID_RegisterRt,
  input  logic        IF_ID_UsesRt,
  input  logic        IF_ID_Branch,
  input  logic        Branch_Taken,
  input  logic        Jump,
  input  logic        ID_EX_RegWrite,
  input  logic        ID_EX_MemRead,
  input  logic [4:0]  ID_EX_RegWriteDst,
  input  logic        ID_EX_MulDiv,
  input  logic        EX_MEM_MemRead,
  input  logic [4:0]  EX_MEM_RegWriteDst,
  input  logic        EX_MEM_MemReq,
  input  logic        Mem_Ready,
  output logic        PC_Write,
  output logic        IF_ID_Write,
  output logic        IF_ID_Flush,
  output logic        ID_EX_Write,
  output logic        ID_EX_Flush,
  output logic        EX_MEM_Write,
  output logic        EX_MEM_Flush,
  output logic        MEM_WB_Write,
  output logic [31:0] Stall_Count,
  output logic        Mem_Timeout
);

  localparam int MDW = $clog2(MD_LAT) + 1;
  localparam int WW  = $clog2(MEM_TIMEOUT + 1);
  localparam logic [MDW-1:0] MD_INIT = MDW'(MD_LAT - 1);
  localparam logic [MDW-1:0] MD_ONE  = MDW'(1);
  localparam logic [WW-1:0]  W_MAX   = WW'(MEM_TIMEOUT);
  localparam logic           MD_EN   = (MD_LAT > 1);

  logic [MDW-1:0] md_cnt_q, md_cnt_d;
  logic [WW-1:0]  wait_cnt_q, wait_cnt_d;
  logic [31:0]    stall_q, stall_d;
  logic           tout_q, tout_d;

  logic ex_rs, ex_rt, mem_rs, mem_rt;
  logic mem_freeze, md_stall, load_use;
  logic br_ex, br_mem, redirect;

  assign ex_rs  = (ID_EX_RegWriteDst != 5'd0) &&
                  (ID_EX_RegWriteDst == IF_ID_RegisterRs);
  assign ex_rt  = (ID_EX_RegWriteDst != 5'd0) &&
                  (ID_EX_RegWriteDst == IF_ID_RegisterRt);
  assign mem_rs = (EX_MEM_RegWriteDst != 5'd0) &&
                  (EX_MEM_RegWriteDst == IF_ID_RegisterRs);
  assign mem_rt = (EX_MEM_RegWriteDst != 5'd0) &&
                  (EX_MEM_RegWriteDst == IF_ID_RegisterRt);

  assign mem_freeze = EX_MEM_MemReq & ~Mem_Ready;
  assign md_stall   = (MD_EN && md_cnt_q == '0 && ID_EX_MulDiv) ||
                      (md_cnt_q > MD_ONE);
  assign load_use   = ID_EX_MemRead &
                      (ex_rs | (IF_ID_UsesRt & ex_rt));
  assign br_ex      = IF_ID_Branch & ID_EX_RegWrite & (ex_rs | ex_rt);
  assign br_mem     = IF_ID_Branch & EX_MEM_MemRead & (mem_rs | mem_rt);
  assign redirect   = Branch_Taken | Jump;

  always_comb begin
    PC_Write     = 1'b1;
    IF_ID_Write  = 1'b1;
    IF_ID_Flush  = 1'b0;
    ID_EX_Write  = 1'b1;
    ID_EX_Flush  = 1'b0;
    EX_MEM_Write = 1'b1;
    EX_MEM_Flush = 1'b0;
    MEM_WB_Write = 1'b1;
    if (!reset) begin
      PC_Write = 1'b1;
    end else if (mem_freeze) begin
      PC_Write     = 1'b0;
      IF_ID_Write  = 1'b0;
      ID_EX_Write  = 1'b0;
      EX_MEM_Write = 1'b0;
      MEM_WB_Write = 1'b0;
    end else if (md_stall) begin
      PC_Write     = 1'b0;
      IF_ID_Write  = 1'b0;
      ID_EX_Write  = 1'b0;
      EX_MEM_Flush = 1'b1;
    end else if (load_use | br_ex | br_mem) begin
      PC_Write    = 1'b0;
      IF_ID_Write = 1'b0;
      ID_EX_Flush = 1'b1;
    end else if (redirect) begin
      IF_ID_Flush = 1'b1;
    end
  end

  // The mul/div unit keeps counting through a freeze; only the final
  // release step waits for the pipeline to move.
  always_comb begin
    md_cnt_d = md_cnt_q;
    if (md_cnt_q == '0) begin
      if (MD_EN && ID_EX_MulDiv && !mem_freeze) md_cnt_d = MD_INIT;
    end else if (md_cnt_q > MD_ONE) begin
      md_cnt_d = md_cnt_q - MD_ONE;
    end else if (!mem_freeze) begin
      md_cnt_d = '0;
    end
  end

  always_comb begin
    wait_cnt_d = '0;
    if (mem_freeze) begin
      wait_cnt_d = (wait_cnt_q == W_MAX) ? wait_cnt_q
                                         : wait_cnt_q + WW'(1);
    end
    tout_d  = tout_q | (wait_cnt_d == W_MAX);
    stall_d = stall_q;
    if (!PC_Write && stall_q != 32'hFFFF_FFFF) stall_d = stall_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      md_cnt_q   <= '0;
      wait_cnt_q <= '0;
      stall_q    <= '0;
      tout_q     <= 1'b0;
    end else begin
      md_cnt_q   <= md_cnt_d;
      wait_cnt_q <= wait_cnt_d;
      stall_q    <= stall_d;
      tout_q     <= tout_d;
    end
  end

  assign Stall_Count = stall_q;
  assign Mem_Timeout = tout_q;

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Bench for pipeline_stall_ctrl: directed hazard scenarios then random
// traffic, all compared against a rule-level model of the stall sequencer.
module tb_pipeline_stall_ctrl;

  localparam int MD_LAT      = 8;
  localparam int MEM_TIMEOUT = 64;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic [4:0]  Rs, Rt, DstEx, DstMem;
  logic        UsesRt, Branch, Taken, Jump;
  logic        ExRegWrite, ExMemRead, MulDiv;
  logic        MemMemRead, MemReq, Ready;
  logic        PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Write;
  logic        ID_EX_Flush, EX_MEM_Write, EX_MEM_Flush, MEM_WB_Write;
  logic [31:0] Stall_Count;
  logic        Mem_Timeout;

  pipeline_stall_ctrl #(.MD_LAT(MD_LAT), .MEM_TIMEOUT(MEM_TIMEOUT)) dut (
    .clk(clk), .reset(reset),
    .IF_ID_RegisterRs(Rs), .IF_ID_RegisterRt(Rt),
    .IF_ID_UsesRt(UsesRt), .IF_ID_Branch(Branch),
    .Branch_Taken(Taken), .Jump(Jump),
    .ID_EX_RegWrite(ExRegWrite), .ID_EX_MemRead(ExMemRead),
    .ID_EX_RegWriteDst(DstEx), .ID_EX_MulDiv(MulDiv),
    .EX_MEM_MemRead(MemMemRead), .EX_MEM_RegWriteDst(DstMem),
    .EX_MEM_MemReq(MemReq), .Mem_Ready(Ready),
    .PC_Write(PC_Write), .IF_ID_Write(IF_ID_Write),
    .IF_ID_Flush(IF_ID_Flush), .ID_EX_Write(ID_EX_Write),
    .ID_EX_Flush(ID_EX_Flush), .EX_MEM_Write(EX_MEM_Write),
    .EX_MEM_Flush(EX_MEM_Flush), .MEM_WB_Write(MEM_WB_Write),
    .Stall_Count(Stall_Count), .Mem_Timeout(Mem_Timeout)
  );

  int checks = 0;
  int failures = 0;

  // model: a mul/div in EX has an age (cycles spent computing)
  bit          m_active;
  int          m_age;
  int          m_wait;
  bit          m_tout;
  logic [31:0] m_stalls;
  logic [7:0]  exp_ctrl;
  logic [7:0]  obs_ctrl;

  assign obs_ctrl = {PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Write,
                     ID_EX_Flush, EX_MEM_Write, EX_MEM_Flush, MEM_WB_Write};

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit hit(input logic [4:0] d, input logic [4:0] r);
    return d != 0 && d == r;
  endfunction

  task automatic model_ctrl();
    bit fr, md, lu, bx, bm;
    fr = MemReq && !Ready;
    md = (MD_LAT > 1 && !m_active && MulDiv) ||
         (m_active && m_age < MD_LAT - 1);
    lu = ExMemRead && (hit(DstEx, Rs) || (UsesRt && hit(DstEx, Rt)));
    bx = Branch && ExRegWrite && (hit(DstEx, Rs) || hit(DstEx, Rt));
    bm = Branch && MemMemRead && (hit(DstMem, Rs) || hit(DstMem, Rt));
    if (!reset)                exp_ctrl = 8'b1101_0101;
    else if (fr)               exp_ctrl = 8'b0000_0000;
    else if (md)               exp_ctrl = 8'b0000_0111;
    else if (lu || bx || bm)   exp_ctrl = 8'b0001_1101;
    else if (Taken || Jump)    exp_ctrl = 8'b1111_0101;
    else                       exp_ctrl = 8'b1101_0101;
  endtask

  task automatic model_edge();
    bit fr;
    fr = MemReq && !Ready;
    if (!reset) begin
      m_active = 0; m_age = 0; m_wait = 0; m_tout = 0; m_stalls = 0;
    end else begin
      if (!exp_ctrl[7] && m_stalls != 32'hFFFF_FFFF) m_stalls++;
      if (m_active) begin
        if (m_age < MD_LAT - 1) m_age++;
        else if (!fr) m_active = 0;
      end else if (MD_LAT > 1 && MulDiv && !fr) begin
        m_active = 1;
        m_age = 1;
      end
      if (fr) begin
        if (m_wait < MEM_TIMEOUT) m_wait++;
        if (m_wait >= MEM_TIMEOUT) m_tout = 1;
      end else begin
        m_wait = 0;
      end
    end
  endtask

  task automatic step(input string tag);
    #1;
    model_ctrl();
    chk({tag, " ctrl"}, 32'(obs_ctrl), 32'(exp_ctrl));
    chk({tag, " stalls"}, Stall_Count, m_stalls);
    chk({tag, " timeout"}, 32'(Mem_Timeout), 32'(m_tout));
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic clr();
    Rs = 0; Rt = 0; DstEx = 0; DstMem = 0;
    UsesRt = 0; Branch = 0; Taken = 0; Jump = 0;
    ExRegWrite = 0; ExMemRead = 0; MulDiv = 0;
    MemMemRead = 0; MemReq = 0; Ready = 1;
  endtask

  initial begin
    clr();
    reset = 0;
    m_active = 0; m_age = 0; m_wait = 0; m_tout = 0; m_stalls = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);

    // reset overrides hazards
    ExMemRead = 1; DstEx = 2; Rs = 2; MemReq = 1; Ready = 0;
    #1 chk("rst pc", 32'(PC_Write), 32'd1);
    step("rst");
    chk("rst stalls", Stall_Count, 32'd0);
    reset = 1; clr();
    step("idle");

    // load-use
    ExMemRead = 1; DstEx = 2; Rs = 2;
    #1 chk("lu pc", 32'(PC_Write), 32'd0);
    chk("lu flush", 32'(ID_EX_Flush), 32'd1);
    step("lu");
    clr();
    #1 chk("lu cnt", Stall_Count, 32'd1);
    step("lu after");

    // dst 0 never matches
    ExMemRead = 1; DstEx = 0; Rs = 0;
    #1 chk("r0 pc", 32'(PC_Write), 32'd1);
    step("r0");
    clr();

    // branch vs ALU producer in EX
    Branch = 1; Rs = 3; ExRegWrite = 1; DstEx = 3;
    step("brex");
    clr(); step("brex after");
    // branch vs load: load_use then br_mem
    Branch = 1; Rt = 3; ExRegWrite = 1; ExMemRead = 1; DstEx = 3;
    step("brld1");
    ExRegWrite = 0; ExMemRead = 0; DstEx = 0;
    MemMemRead = 1; DstMem = 3;
    #1 chk("brmem pc", 32'(PC_Write), 32'd0);
    step("brld2");
    MemMemRead = 0; DstMem = 0;
    #1 chk("brld3 pc", 32'(PC_Write), 32'd1);
    step("brld3");
    clr();

    // mul/div occupies EX for MD_LAT cycles
    MulDiv = 1;
    for (int i = 0; i < MD_LAT - 1; i++) begin
      #1 chk("md idex", 32'(ID_EX_Write), 32'd0);
      chk("md exfl", 32'(EX_MEM_Flush), 32'd1);
      step("md");
    end
    #1 chk("md rel", 32'(ID_EX_Write), 32'd1);
    step("md rel");
    MulDiv = 0; step("md after");

    // release cycle hit by memory freeze
    MulDiv = 1;
    for (int i = 0; i < MD_LAT - 1; i++) step("mdf");
    MemReq = 1; Ready = 0;
    #1 chk("mdf frz", 32'(obs_ctrl), 32'd0);
    step("mdf frz");
    Ready = 1;
    #1 chk("mdf rel", 32'(PC_Write), 32'd1);
    step("mdf rel");
    clr(); step("mdf after");

    // redirect flush and its suppression
    Taken = 1;
    #1 chk("tk flush", 32'(IF_ID_Flush), 32'd1);
    step("tk");
    ExMemRead = 1; DstEx = 4; Rs = 4;
    #1 chk("tk lu", 32'(IF_ID_Flush), 32'd0);
    step("tk lu");
    clr(); Jump = 1; step("jmp");
    clr();

    // memory timeout is sticky
    MemReq = 1; Ready = 0;
    for (int i = 0; i < MEM_TIMEOUT; i++) step("wait");
    Ready = 1;
    #1 chk("tout set", 32'(Mem_Timeout), 32'd1);
    step("tout");
    clr(); step("tout hold");
    reset = 0; step("tout rst");
    reset = 1;
    #1 chk("tout clr", 32'(Mem_Timeout), 32'd0);
    step("tout clr");

    // reset mid mul/div leaves no residual stall
    MulDiv = 1;
    repeat (3) step("mdr");
    reset = 0; step("mdr rst");
    reset = 1; MulDiv = 0;
    #1 chk("mdr pc", 32'(PC_Write), 32'd1);
    step("mdr after");

    for (int i = 0; i < 500; i++) begin
      reset      = ($urandom_range(0, 59) != 0);
      Rs         = 5'($urandom_range(0, 3));
      Rt         = 5'($urandom_range(0, 3));
      DstEx      = 5'($urandom_range(0, 3));
      DstMem     = 5'($urandom_range(0, 3));
      UsesRt     = 1'($urandom_range(0, 1));
      Branch     = ($urandom_range(0, 3) == 0);
      Taken      = ($urandom_range(0, 3) == 0);
      Jump       = ($urandom_range(0, 7) == 0);
      ExRegWrite = 1'($urandom_range(0, 1));
      ExMemRead  = ($urandom_range(0, 3) == 0);
      MulDiv     = ($urandom_range(0, 5) == 0);
      MemMemRead = ($urandom_range(0, 3) == 0);
      MemReq     = ($urandom_range(0, 3) == 0);
      Ready      = 1'($urandom_range(0, 1));
      step("rnd");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
